// File: rtl/sw_axis_pkg.sv
// Shared AXI-Stream definitions for the switch datapath: beat widths,
// the stored beat layout and the transmit FIFO frame-state encoding.
package sw_axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = 4;
    localparam int AXIS_BEAT_W = 1 + AXIS_KEEP_W + AXIS_DATA_W;

    // One stored beat; 'last' sits in the MSB so the RAM word is {tlast, tkeep, tdata}
    typedef struct packed {
        logic                   last;
        logic [AXIS_KEEP_W-1:0] keep;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    // PASS stores the incoming frame, DROP swallows the rest of an oversize frame
    typedef enum logic [0:0] {
        PASS = 1'b0,
        DROP = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. The array carries no reset so it maps onto block RAM; the read
// register holds its value whenever rd_en is low, which lets the caller park
// a fetched word while the downstream stage is stalled.
module sdp_ram #(
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, held while not enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/txd_frame_fifo.sv
// Per-port store-and-forward transmit FIFO. Beats from the crossbar are
// written as they arrive, but only frames whose tlast has been stored are
// visible to the read side, so the MAC never sees a partial frame. A frame
// that cannot fit in the whole buffer is rewound and swallowed, and counted.
//
// Read path: RAM fetch register (ram_vld_reg) feeding the output register.
// rd_ptr_reg advances only when a beat leaves the fetch register, so a beat
// parked there still occupies its RAM slot and is included in the occupancy.
// fetch_ptr_reg is the RAM read address, at most one ahead of rd_ptr_reg.
module txd_frame_fifo
    import sw_axis_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int DROP_CNT_W = 16
) (
    input  logic                   glb_clk,
    input  logic                   glb_areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [31:0]            fifo_space_used,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    // Frame state and pointers; pointer MSB separates full from empty
    fifo_state_t           state_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      commit_ptr_reg;
    logic [PTR_W-1:0]      fetch_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      frames_ready_reg;
    logic [PTR_W-1:0]      frames_ready_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    // Read pipeline
    logic                   ram_vld_reg;
    logic [AXIS_BEAT_W-1:0] ram_q;
    logic                   out_vld_reg;
    axis_beat_t             out_beat_reg;

    // Derived control
    logic [PTR_W-1:0] used_beats;
    logic             full;
    logic             oversize;
    logic             wr_en;
    logic             out_free;
    logic             load_out;
    logic             rd_en;
    logic             m_last_hs;
    axis_beat_t       wr_beat;

    assign used_beats = wr_ptr_reg - rd_ptr_reg;
    assign full       = (used_beats == CAPACITY);

    // Buffer full of a single unfinished frame: it can never complete
    assign oversize = (state_reg == PASS) && full && (frames_ready_reg == '0);

    // Registered-state only: while dropping everything is accepted,
    // otherwise accept until the buffer is full
    assign s_axis_tready = (state_reg == DROP) || !full;

    assign wr_en   = s_axis_tvalid && s_axis_tready && (state_reg == PASS);
    assign wr_beat = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

    assign out_free  = !out_vld_reg || m_axis_tready;
    assign load_out  = ram_vld_reg && out_free;
    assign rd_en     = (fetch_ptr_reg != commit_ptr_reg) && (!ram_vld_reg || load_out);
    assign m_last_hs = out_vld_reg && m_axis_tready && out_beat_reg.last;

    sdp_ram #(
        .WIDTH  (AXIS_BEAT_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (glb_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
        .wr_data (wr_beat),
        .rd_en   (rd_en),
        .rd_addr (fetch_ptr_reg[DEPTH_LOG2-1:0]),
        .rd_data (ram_q)
    );

    // Write side: store beats, publish a frame on tlast, rewind an oversize frame
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            state_reg      <= PASS;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                PASS: begin
                    if (oversize) begin
                        wr_ptr_reg <= commit_ptr_reg;
                        state_reg  <= DROP;
                        if (drop_cnt_reg != '1) begin
                            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
                        end
                    end else if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        if (s_axis_tlast) begin
                            commit_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_reg <= PASS;
                    end
                end
                default: state_reg <= PASS;
            endcase
        end
    end

    // Count of stored-complete frames whose tlast has not yet left on m_axis
    always_comb begin
        frames_ready_next = frames_ready_reg;
        if (wr_en && s_axis_tlast && !m_last_hs) begin
            frames_ready_next = frames_ready_reg + PTR_ONE;
        end else if (m_last_hs && !(wr_en && s_axis_tlast)) begin
            frames_ready_next = frames_ready_reg - PTR_ONE;
        end
    end

    // Register the frame count
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            frames_ready_reg <= '0;
        end else begin
            frames_ready_reg <= frames_ready_next;
        end
    end

    // Read side: fetch committed beats and track the fetch register occupancy
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            fetch_ptr_reg <= '0;
            rd_ptr_reg    <= '0;
            ram_vld_reg   <= 1'b0;
        end else begin
            if (rd_en) begin
                fetch_ptr_reg <= fetch_ptr_reg + PTR_ONE;
            end
            if (load_out) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (rd_en) begin
                ram_vld_reg <= 1'b1;
            end else if (load_out) begin
                ram_vld_reg <= 1'b0;
            end
        end
    end

    // Output register: refill when empty or draining, hold while stalled
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            out_vld_reg  <= 1'b0;
            out_beat_reg <= '0;
        end else begin
            if (load_out) begin
                out_vld_reg  <= 1'b1;
                out_beat_reg <= axis_beat_t'(ram_q);
            end else if (m_axis_tready) begin
                out_vld_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_vld_reg;
    assign m_axis_tdata  = out_beat_reg.data;
    assign m_axis_tkeep  = out_beat_reg.keep;
    assign m_axis_tlast  = out_beat_reg.last;

    // Occupancy seen by the frame decoders: RAM (committed or not) plus output register
    assign fifo_space_used = 32'(used_beats) + 32'(out_vld_reg);
    assign drop_cnt        = drop_cnt_reg;

endmodule
